// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// holds it until consumed, and handles branch redirects including in-flight aborts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] abort_pc_q, abort_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      abort_pc_q <= RESET_PC;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      abort_pc_q <= abort_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    abort_pc_d = abort_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_en) pc_d = redir_pc;
      end
      REQ: begin
        if (redirect_en) begin
          pc_d = redir_pc;
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            // The old request is still outstanding; remember where it went.
            abort_pc_d = pc_q;
            state_d    = DRAIN;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (inst_ready) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redirect_en) pc_d = redir_pc;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr  = (state_q == DRAIN) ? abort_pc_q : pc_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch handshake, stalls, redirects,
// address wrap and asynchronous reset mid-request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".vld"}, {31'b0, inst_valid}, {31'b0, vld});
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    #3;
    chk_out("rst", 1'b0, 32'h0, 1'b0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.inst_pc", inst_pc, 32'h0);

    // Basic fetch with ack tied high
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013; inst_ready = 1'b1;
    step();
    chk_out("first_req", 1'b1, 32'h0, 1'b0);
    step();
    chk_out("first_hold", 1'b0, 32'h0000_0004, 1'b1);
    chk("first.inst", inst, 32'h0000_0013);
    chk("first.inst_pc", inst_pc, 32'h0);
    imem_ack = 1'b0;
    step();
    chk_out("second_req", 1'b1, 32'h0000_0004, 1'b0);

    // Asynchronous reset between edges while requesting
    #2 rst = 1'b1;
    #1;
    chk_out("rst_mid_req", 1'b0, 32'h0, 1'b0);
    chk("rst_mid_req.inst", inst, 32'h0);
    #1 rst = 1'b0;
    step();
    chk_out("after_rst", 1'b1, 32'h0, 1'b0);

    // Ack delayed three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("ack_wait", 1'b1, 32'h0, 1'b0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; inst_ready = 1'b0;
    step();
    chk_out("late_ack_hold", 1'b0, 32'h0000_0004, 1'b1);
    chk("late_ack.inst", inst, 32'h1111_1111);
    imem_ack = 1'b0;

    // Consumer stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall", 1'b0, 32'h0000_0004, 1'b1);
      chk("stall.inst", inst, 32'h1111_1111);
      chk("stall.inst_pc", inst_pc, 32'h0);
    end
    inst_ready = 1'b1;
    step();
    chk_out("stall_release", 1'b1, 32'h0000_0004, 1'b0);
    inst_ready = 1'b0;

    // Redirect without ack: drain the old request, discard its data
    redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    chk_out("drain0", 1'b1, 32'h0000_0004, 1'b0);
    redirect_en = 1'b0;
    step();
    chk_out("drain1", 1'b1, 32'h0000_0004, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk_out("drain_done", 1'b1, 32'h0000_0100, 1'b0);
    chk("drain_done.inst", inst, 32'h1111_1111);
    imem_rdata = 32'h2222_2222;
    step();
    chk_out("after_drain_hold", 1'b0, 32'h0000_0104, 1'b1);
    chk("after_drain.inst", inst, 32'h2222_2222);
    chk("after_drain.inst_pc", inst_pc, 32'h0000_0100);
    imem_ack = 1'b0;

    // Redirect in HOLD with inst_ready the same cycle
    redirect_en = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
    step();
    chk_out("hold_redirect", 1'b1, 32'h0000_0200, 1'b0);
    inst_ready = 1'b0;

    // Redirect in REQ with ack the same cycle
    redirect_pc = 32'h0000_0300; imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();
    chk_out("req_redirect_ack", 1'b1, 32'h0000_0300, 1'b0);
    chk("req_redirect_ack.inst", inst, 32'h2222_2222);

    // Repeated redirects in DRAIN, the last one coinciding with ack
    redirect_pc = 32'h0000_0400; imem_ack = 1'b0;
    step();
    chk_out("drain_a", 1'b1, 32'h0000_0300, 1'b0);
    redirect_pc = 32'h0000_0500;
    step();
    chk_out("drain_b", 1'b1, 32'h0000_0300, 1'b0);
    redirect_pc = 32'h0000_0600; imem_ack = 1'b1;
    step();
    chk_out("drain_exit", 1'b1, 32'h0000_0600, 1'b0);

    // Address wrap at the top of memory (low bits of redirect ignored)
    redirect_pc = 32'hFFFF_FFFF;
    step();
    chk_out("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0);
    redirect_en = 1'b0; imem_rdata = 32'h0000_0033;
    step();
    chk_out("wrap_hold", 1'b0, 32'h0000_0000, 1'b1);
    chk("wrap.inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap.inst", inst, 32'h0000_0033);
    imem_ack = 1'b0; inst_ready = 1'b1;
    step();
    chk_out("wrap_next", 1'b1, 32'h0000_0000, 1'b0);

    // Reset mid-REQ with ack still high: the late ack must be ignored
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    #2 rst = 1'b1;
    #1;
    chk_out("rst_late_ack", 1'b0, 32'h0, 1'b0);
    #1 rst = 1'b0;
    step();
    chk_out("rst_late_ack_req", 1'b1, 32'h0, 1'b0);
    chk("rst_late_ack.inst", inst, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
